axidefslave: RTL and testbench



---
 rtl/axidefslave.sv | 184 ++++++++++++++++++
 tb/tb_axidefslave.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axidefslave.sv
// AXI4 default slave: terminates every burst on an unmapped range with an
// error response, keeps saturating burst counters and logs the address of
// the first offending request since reset or clear.
module axidefslave #(
  parameter int C_AXI_ID_WIDTH   = 2,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter bit OPT_DECERR       = 1'b1,
  parameter logic [C_AXI_DATA_WIDTH-1:0] RDATA_FILL = '0,
  parameter int LGAWFIFO         = 2,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  input  logic                        S_AXI_WLAST,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic                        S_AXI_RLAST,
  output logic [1:0]                  S_AXI_RRESP,
  input  logic                        i_clear,
  output logic [CNT_WIDTH-1:0]        o_wr_errors,
  output logic [CNT_WIDTH-1:0]        o_rd_errors,
  output logic                        o_first_valid,
  output logic                        o_first_is_write,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_first_addr
);
  localparam int DEPTH = 1 << LGAWFIFO;
  localparam logic [1:0] ERESP = OPT_DECERR ? 2'b11 : 2'b10;

  typedef enum logic {IDLE, BURST} rstate_t;

  // Burst length on the write side is delimited by WLAST alone.
  logic unused_awlen;
  assign unused_awlen = ^S_AXI_AWLEN;

  logic [C_AXI_ID_WIDTH-1:0] fifo_q [DEPTH];
  logic [LGAWFIFO:0]         wptr_q, rptr_q;
  logic                      full, empty;
  logic                      aw_hs, wl_hs, b_hs, ar_hs, rl_hs;
  logic                      bvalid_q;
  logic [C_AXI_ID_WIDTH-1:0] bid_q;
  rstate_t                   state_q;
  logic [7:0]                beats_q;
  logic                      rvalid_q, rlast_q;
  logic [C_AXI_ID_WIDTH-1:0] rid_q;
  logic [CNT_WIDTH-1:0]      wr_q, rd_q;
  logic                      fv_q, fw_q;
  logic [C_AXI_ADDR_WIDTH-1:0] faddr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[LGAWFIFO] != rptr_q[LGAWFIFO]) &&
                 (wptr_q[LGAWFIFO-1:0] == rptr_q[LGAWFIFO-1:0]);

  assign S_AXI_AWREADY = !full;
  // A last beat may only complete when the B slot is free or draining.
  assign S_AXI_WREADY  = !empty && (!S_AXI_WLAST || !bvalid_q || S_AXI_BREADY);
  assign S_AXI_ARREADY = (state_q == IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign wl_hs = S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST;
  assign b_hs  = bvalid_q && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rl_hs = rvalid_q && S_AXI_RREADY && rlast_q;

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BID    = bid_q;
  assign S_AXI_BRESP  = ERESP;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RID    = rid_q;
  assign S_AXI_RLAST  = rlast_q;
  assign S_AXI_RRESP  = ERESP;
  assign S_AXI_RDATA  = RDATA_FILL;

  assign o_wr_errors      = wr_q;
  assign o_rd_errors      = rd_q;
  assign o_first_valid    = fv_q;
  assign o_first_is_write = fw_q;
  assign o_first_addr     = faddr_q;

  // ID storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_hs) fifo_q[wptr_q[LGAWFIFO-1:0]] <= S_AXI_AWID;
  end

  // Write-ID FIFO pointers and the single-entry B response register.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
    end else begin
      if (aw_hs) wptr_q <= wptr_q + (LGAWFIFO+1)'(1);
      if (wl_hs) begin
        rptr_q   <= rptr_q + (LGAWFIFO+1)'(1);
        bid_q    <= fifo_q[rptr_q[LGAWFIFO-1:0]];
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read FSM: accept one AR, then stream ARLEN+1 error beats.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q  <= IDLE;
      beats_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (S_AXI_ARVALID) begin
          rid_q    <= S_AXI_ARID;
          beats_q  <= S_AXI_ARLEN;
          rvalid_q <= 1'b1;
          rlast_q  <= (S_AXI_ARLEN == 8'd0);
          state_q  <= BURST;
        end
        BURST: if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            state_q  <= IDLE;
          end else begin
            beats_q <= beats_q - 8'd1;
            rlast_q <= (beats_q == 8'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating burst counters; a clear that coincides with an event keeps it.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (i_clear)           wr_q <= b_hs ? CNT_WIDTH'(1) : '0;
      else if (b_hs && wr_q != '1) wr_q <= wr_q + CNT_WIDTH'(1);
      if (i_clear)           rd_q <= rl_hs ? CNT_WIDTH'(1) : '0;
      else if (rl_hs && rd_q != '1) rd_q <= rd_q + CNT_WIDTH'(1);
    end
  end

  // First-error log; AW has priority over a same-cycle AR.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      fv_q    <= 1'b0;
      fw_q    <= 1'b0;
      faddr_q <= '0;
    end else if ((aw_hs || ar_hs) && (!fv_q || i_clear)) begin
      fv_q    <= 1'b1;
      fw_q    <= aw_hs;
      faddr_q <= aw_hs ? S_AXI_AWADDR : S_AXI_ARADDR;
    end else if (i_clear) begin
      fv_q    <= 1'b0;
      fw_q    <= 1'b0;
      faddr_q <= '0;
    end
  end
endmodule

// File: tb/tb_axidefslave.sv
// Bench for axidefslave: directed sequences, a write-channel vector table and
// a randomized run against a queue-based transaction model.
module tb_axidefslave;
  localparam int IW = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [DW-1:0] FILL = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic awvalid, wvalid, wlast, bready, arvalid, rready, clr;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;

  logic awready, wready, bvalid, arready, rvalid, rlast, fv, fw;
  logic [IW-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [15:0] wrc, rdc;
  logic [AW-1:0] faddr;

  logic unused_awr2, unused_wr2, unused_bv2, unused_arr2, unused_rv2, unused_rl2;
  logic unused_fv2, unused_fw2;
  logic [IW-1:0] unused_bid2, unused_rid2;
  logic [1:0] unused_bresp2, rresp2;
  logic [DW-1:0] unused_rdata2;
  logic [1:0] wrc2, rdc2;
  logic [AW-1:0] unused_faddr2;

  axidefslave #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW),
    .OPT_DECERR(1'b1), .RDATA_FILL(FILL), .LGAWFIFO(2), .CNT_WIDTH(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARID(arid),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
    .S_AXI_RLAST(rlast), .S_AXI_RRESP(rresp),
    .i_clear(clr), .o_wr_errors(wrc), .o_rd_errors(rdc),
    .o_first_valid(fv), .o_first_is_write(fw), .o_first_addr(faddr));

  // Narrow-counter, SLVERR variant driven by the same stimulus.
  axidefslave #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW),
    .OPT_DECERR(1'b0), .LGAWFIFO(2), .CNT_WIDTH(2)) dut2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(unused_awr2), .S_AXI_AWID(awid),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(unused_wr2), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(unused_bv2), .S_AXI_BREADY(bready), .S_AXI_BID(unused_bid2),
    .S_AXI_BRESP(unused_bresp2),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(unused_arr2), .S_AXI_ARID(arid),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_RVALID(unused_rv2), .S_AXI_RREADY(rready), .S_AXI_RID(unused_rid2),
    .S_AXI_RDATA(unused_rdata2), .S_AXI_RLAST(unused_rl2), .S_AXI_RRESP(rresp2),
    .i_clear(clr), .o_wr_errors(wrc2), .o_rd_errors(rdc2),
    .o_first_valid(unused_fv2), .o_first_is_write(unused_fw2), .o_first_addr(unused_faddr2));

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle; #1; endtask
  task automatic cyc; @(posedge clk); #1; endtask

  task automatic idle_inputs;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0;
    rready = 0; clr = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    settle();
  endtask

  // Write-channel vectors: inputs for one cycle and the outputs expected in it.
  typedef struct {
    logic awv; logic [IW-1:0] awid; logic wv, wl, br;
    logic e_awr, e_wr, e_bv; logic [IW-1:0] e_bid; int e_wrc;
  } wvec_t;
  wvec_t tbl [17];

  function automatic wvec_t mk(logic awv_, logic [IW-1:0] id_, logic wv_, logic wl_, logic br_,
                               logic ea, logic ew, logic eb, logic [IW-1:0] ebid, int ewc);
    wvec_t t;
    t.awv = awv_; t.awid = id_; t.wv = wv_; t.wl = wl_; t.br = br_;
    t.e_awr = ea; t.e_wr = ew; t.e_bv = eb; t.e_bid = ebid; t.e_wrc = ewc;
    return t;
  endfunction

  // Reference model state for the randomized run.
  typedef struct { logic [IW-1:0] id; bit last; } rbeat_t;
  logic [IW-1:0] m_awq [$];
  rbeat_t        m_rq [$];
  bit            m_bv, m_fv, m_fw;
  logic [IW-1:0] m_bid;
  logic [AW-1:0] m_faddr;
  int            m_wr, m_rd, m_wr2, m_rd2;

  function automatic int sat_inc(int v, int mx, bit ev, bit c);
    if (c) return ev ? 1 : 0;
    if (ev && v < mx) return v + 1;
    return v;
  endfunction

  initial begin
    int beats;
    bit stalled;
    logic [IW-1:0] prid;
    logic prl;
    idle_inputs();

    // ---- reset values ----
    do_reset();
    chk("rst_awready", awready, 1); chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_bid", bid, 0);
    chk("rst_arready", arready, 1); chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);     chk("rst_rid", rid, 0);
    chk("rst_wrc", wrc, 0);         chk("rst_rdc", rdc, 0);
    chk("rst_fv", fv, 0);           chk("rst_fw", fw, 0);
    chk("rst_faddr", faddr, 0);

    // ---- simultaneous AW and AR as the very first transaction ----
    awvalid = 1; awid = 1; awaddr = 32'h4000_1000;
    arvalid = 1; arid = 2; arlen = 0; araddr = 32'h5000_2000; rready = 1;
    settle(); chk("sim_awready", awready, 1); chk("sim_arready", arready, 1);
    cyc();
    awvalid = 0; arvalid = 0; settle();
    chk("sim_fv", fv, 1); chk("sim_fw", fw, 1); chk("sim_faddr", faddr, 32'h4000_1000);
    chk("sim_rvalid", rvalid, 1); chk("sim_rlast", rlast, 1); chk("sim_rid", rid, 2);
    chk("sim_rdata", rdata, FILL); chk("sim_rresp", rresp, 2'b11); chk("sim_rresp2", rresp2, 2'b10);
    cyc();
    wvalid = 1; wlast = 1; bready = 1; settle();
    chk("sim_wready", wready, 1);
    cyc();
    wvalid = 0; settle();
    chk("sim_bvalid", bvalid, 1); chk("sim_bid", bid, 1); chk("sim_bresp", bresp, 2'b11);
    cyc(); settle();
    chk("sim_wrc", wrc, 1); chk("sim_rdc", rdc, 1); chk("sim_bvalid_clr", bvalid, 0);

    // ---- queued writes and B backpressure, table driven ----
    do_reset();
    tbl[0]  = mk(1,0,0,0,1, 1,0,0,0,0);
    tbl[1]  = mk(1,1,0,0,1, 1,1,0,0,0);
    tbl[2]  = mk(1,2,0,0,1, 1,1,0,0,0);
    tbl[3]  = mk(1,3,0,0,1, 1,1,0,0,0);
    tbl[4]  = mk(1,0,0,0,1, 0,1,0,0,0);
    tbl[5]  = mk(0,0,1,0,1, 0,1,0,0,0);
    tbl[6]  = mk(0,0,1,1,1, 0,1,0,0,0);
    tbl[7]  = mk(0,0,1,0,1, 1,1,1,0,0);
    tbl[8]  = mk(0,0,1,1,1, 1,1,0,0,1);
    tbl[9]  = mk(0,0,0,0,0, 1,1,1,1,1);
    tbl[10] = mk(0,0,1,1,0, 1,0,1,1,1);
    tbl[11] = mk(0,0,1,0,0, 1,1,1,1,1);
    tbl[12] = mk(0,0,1,1,1, 1,1,1,1,1);
    tbl[13] = mk(0,0,1,0,1, 1,1,1,2,2);
    tbl[14] = mk(0,0,1,1,1, 1,1,0,0,3);
    tbl[15] = mk(0,0,1,0,1, 1,0,1,3,3);
    tbl[16] = mk(0,0,0,0,1, 1,0,0,0,4);
    awaddr = 32'h6000_0040;
    for (int i = 0; i < 17; i++) begin
      awvalid = tbl[i].awv; awid = tbl[i].awid;
      wvalid = tbl[i].wv; wlast = tbl[i].wl; bready = tbl[i].br;
      settle();
      chk($sformatf("tbl%0d_awready", i), awready, tbl[i].e_awr);
      chk($sformatf("tbl%0d_wready", i), wready, tbl[i].e_wr);
      chk($sformatf("tbl%0d_bvalid", i), bvalid, tbl[i].e_bv);
      if (tbl[i].e_bv) chk($sformatf("tbl%0d_bid", i), bid, tbl[i].e_bid);
      chk($sformatf("tbl%0d_wrc", i), wrc, tbl[i].e_wrc);
      cyc();
    end
    idle_inputs(); settle();
    chk("tbl_wrc2_sat", wrc2, 3);
    chk("tbl_faddr", faddr, 32'h6000_0040); chk("tbl_fw", fw, 1);

    // ---- single read, then a backpressured read, in a fresh segment ----
    do_reset();
    arvalid = 1; arid = 2; arlen = 3; araddr = 32'h7000_0100; rready = 1;
    settle(); chk("rd1_arready", arready, 1); chk("rd1_rvalid0", rvalid, 0);
    cyc();
    arvalid = 0;
    for (int b = 0; b < 4; b++) begin
      settle();
      chk($sformatf("rd1_b%0d_rvalid", b), rvalid, 1);
      chk($sformatf("rd1_b%0d_rid", b), rid, 2);
      chk($sformatf("rd1_b%0d_rresp", b), rresp, 2'b11);
      chk($sformatf("rd1_b%0d_rlast", b), rlast, (b == 3));
      chk($sformatf("rd1_b%0d_arready", b), arready, 0);
      cyc();
    end
    settle();
    chk("rd1_rvalid_end", rvalid, 0); chk("rd1_arready_end", arready, 1);
    chk("rd1_rdc", rdc, 1); chk("rd1_fv", fv, 1); chk("rd1_fw", fw, 0);
    chk("rd1_faddr", faddr, 32'h7000_0100);

    arvalid = 1; arid = 1; arlen = 7; araddr = 32'h7000_0200; rready = 0;
    settle(); cyc();
    arvalid = 0;
    beats = 0; stalled = 0; prid = '0; prl = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      rready = (c % 2 == 0);
      settle();
      chk("bp_rvalid", rvalid, 1); chk("bp_arready", arready, 0); chk("bp_rid", rid, 1);
      if (stalled) begin
        chk("bp_stable_rid", rid, prid); chk("bp_stable_rlast", rlast, prl);
      end
      if (rready) begin
        chk($sformatf("bp_b%0d_rlast", beats), rlast, (beats == 7));
        beats++; stalled = 0;
      end else begin
        prid = rid; prl = rlast; stalled = 1;
      end
      cyc();
    end
    rready = 0; settle();
    chk("bp_beats", beats, 8); chk("bp_rvalid_end", rvalid, 0);
    chk("bp_arready_end", arready, 1); chk("bp_rdc", rdc, 2);
    chk("bp_faddr_kept", faddr, 32'h7000_0100);

    // ---- clear coinciding with a B handshake ----
    awvalid = 1; awid = 1; awaddr = 32'h8000_0000; settle(); cyc();
    awid = 2; wvalid = 1; wlast = 1; bready = 1; settle();
    chk("clr_wready", wready, 1); cyc();
    awvalid = 0; settle();
    chk("clr_bvalid1", bvalid, 1); chk("clr_bid1", bid, 1); cyc();
    wvalid = 0; bready = 0; settle();
    chk("clr_wrc_pre", wrc, 1); chk("clr_bid2", bid, 2); chk("clr_fv_pre", fv, 1);
    clr = 1; bready = 1; cyc();
    clr = 0; bready = 0; settle();
    chk("clr_wrc", wrc, 1); chk("clr_rdc", rdc, 0); chk("clr_fv", fv, 0);
    chk("clr_faddr", faddr, 0); chk("clr_bvalid", bvalid, 0);

    // ---- reset asserted in the middle of a read burst ----
    arvalid = 1; arid = 3; arlen = 7; araddr = 32'h9000_0000; rready = 1;
    settle(); cyc();
    arvalid = 0; settle(); chk("mr_b1_rvalid", rvalid, 1); cyc();
    settle(); chk("mr_b2_rvalid", rvalid, 1);
    rst = 1; settle();
    chk("mr_rvalid_rst", rvalid, 0); chk("mr_arready_rst", arready, 1);
    chk("mr_wrc_rst", wrc, 0);
    cyc(); cyc();
    rst = 0; settle();
    chk("mr_arready", arready, 1); chk("mr_rvalid", rvalid, 0);
    chk("mr_wrc", wrc, 0); chk("mr_rdc", rdc, 0); chk("mr_fv", fv, 0);
    cyc(); settle(); chk("mr_rvalid_after", rvalid, 0);

    // ---- randomized run against the transaction model ----
    do_reset();
    m_awq.delete(); m_rq.delete();
    m_bv = 0; m_bid = '0; m_fv = 0; m_fw = 0; m_faddr = '0;
    m_wr = 0; m_rd = 0; m_wr2 = 0; m_rd2 = 0;
    for (int n = 0; n < 3000; n++) begin
      bit e_awr, e_wr, e_arr, e_rv, aw_h, wl_h, b_h, ar_h, r_h;
      awvalid = ($urandom_range(0, 2) == 0); awid = IW'($urandom); awaddr = $urandom;
      wvalid = $urandom_range(0, 1); wlast = $urandom_range(0, 1);
      bready = ($urandom_range(0, 3) != 0);
      arvalid = $urandom_range(0, 1); arid = IW'($urandom); araddr = $urandom;
      arlen = ($urandom_range(0, 7) == 0) ? 8'd7 : 8'($urandom_range(0, 3));
      rready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      awlen = 8'($urandom);
      settle();
      e_awr = (m_awq.size() < 4);
      e_wr  = (m_awq.size() > 0) && (!wlast || !m_bv || bready);
      e_arr = (m_rq.size() == 0);
      e_rv  = (m_rq.size() > 0);
      chk("rnd_awready", awready, e_awr); chk("rnd_wready", wready, e_wr);
      chk("rnd_bvalid", bvalid, m_bv);    chk("rnd_arready", arready, e_arr);
      chk("rnd_rvalid", rvalid, e_rv);
      if (m_bv) chk("rnd_bid", bid, m_bid);
      if (e_rv) begin
        chk("rnd_rid", rid, m_rq[0].id); chk("rnd_rlast", rlast, m_rq[0].last);
        chk("rnd_rdata", rdata, FILL); chk("rnd_rresp2", rresp2, 2'b10);
      end
      chk("rnd_wrc", wrc, m_wr); chk("rnd_rdc", rdc, m_rd);
      chk("rnd_wrc2", wrc2, m_wr2); chk("rnd_rdc2", rdc2, m_rd2);
      chk("rnd_fv", fv, m_fv);
      if (m_fv) begin chk("rnd_fw", fw, m_fw); chk("rnd_faddr", faddr, m_faddr); end
      // advance the model by this cycle's handshakes
      aw_h = awvalid && e_awr;
      wl_h = wvalid && e_wr && wlast;
      b_h  = m_bv && bready;
      ar_h = arvalid && e_arr;
      r_h  = e_rv && rready;
      m_wr  = sat_inc(m_wr, 65535, b_h, clr);
      m_wr2 = sat_inc(m_wr2, 3, b_h, clr);
      m_rd  = sat_inc(m_rd, 65535, r_h && m_rq[0].last, clr);
      m_rd2 = sat_inc(m_rd2, 3, r_h && m_rq[0].last, clr);
      if (wl_h) begin m_bid = m_awq.pop_front(); m_bv = 1; end
      else if (b_h) m_bv = 0;
      if (aw_h) m_awq.push_back(awid);
      if (r_h) void'(m_rq.pop_front());
      if (ar_h) for (int k = 0; k <= int'(arlen); k++) m_rq.push_back('{arid, (k == int'(arlen))});
      if ((aw_h || ar_h) && (!m_fv || clr)) begin
        m_fv = 1; m_fw = aw_h; m_faddr = aw_h ? awaddr : araddr;
      end else if (clr) begin
        m_fv = 0; m_fw = 0; m_faddr = '0;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
